// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, stall codes, and IF/ID slot types.
package core_pkg;

    localparam int MEM_ADDR_WIDTH = 32;
    localparam int REG_DATA_WIDTH = 32;
    localparam int STALL_WIDTH    = 2;

    // Global stall codes driven by the hazard unit; only STALL_LOAD freezes IF/ID.
    localparam logic [STALL_WIDTH-1:0] STALL_NONE = 2'd0;
    localparam logic [STALL_WIDTH-1:0] STALL_LOAD = 2'd1;
    localparam logic [STALL_WIDTH-1:0] STALL_MEM  = 2'd2;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // One IF/ID pipeline slot.
    typedef struct packed {
        logic [MEM_ADDR_WIDTH-1:0] pc;
        logic [REG_DATA_WIDTH-1:0] inst;
        logic                      valid;
    } if_id_t;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } ifid_state_e;

endpackage

// File: rtl/sat_counter.sv
// Unsigned event counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: synchronous clear wins, increments stop once all ones is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures the fetched pc/instruction, freezes on
// load-use stall, turns the slot into a NOP bubble on a taken branch, and
// keeps saturating stall/flush event counters for performance debug.
module if_id_reg
    import core_pkg::*;
#(
    parameter int               ADDR_W = MEM_ADDR_WIDTH,
    parameter int               DATA_W = REG_DATA_WIDTH,
    parameter logic [DATA_W-1:0] NOP   = NOP_INST,
    parameter int               CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [STALL_WIDTH-1:0] stall,
    input  logic                   flush,
    input  logic [ADDR_W-1:0]      if_pc,
    input  logic [DATA_W-1:0]      if_inst,
    output logic [ADDR_W-1:0]      id_pc,
    output logic [DATA_W-1:0]      id_inst,
    output logic                   id_valid,
    output logic                   hold_o,
    output logic [CNT_W-1:0]       cnt_stall,
    output logic [CNT_W-1:0]       cnt_flush
);

    if_id_t      slot_q;
    if_id_t      slot_d;
    ifid_state_e state_q;
    ifid_state_e state_d;
    logic        hold_q;
    logic        stall_load;
    logic        stall_evt;

    // Any stall code other than a load-use stall is meant for other stages.
    assign stall_load = (stall == STALL_LOAD);
    // A flush on the same edge overrides the stall, so it is not a stall cycle.
    assign stall_evt  = stall_load && !flush;

    // Next slot and state with priority flush > load stall > capture.
    always_comb begin
        slot_d  = slot_q;
        state_d = state_q;
        if (flush) begin
            slot_d.pc    = if_pc;
            slot_d.inst  = NOP;
            slot_d.valid = 1'b0;
            state_d      = RUN;
        end else if (stall_load) begin
            // Hold everything; a held bubble therefore stays a bubble.
            state_d = HOLD;
        end else begin
            slot_d.pc    = if_pc;
            slot_d.inst  = if_inst;
            slot_d.valid = 1'b1;
            state_d      = RUN;
        end
    end

    // Slot, FSM state and registered hold flag, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q.pc    <= '0;
            slot_q.inst  <= NOP;
            slot_q.valid <= 1'b0;
            state_q      <= RUN;
            hold_q       <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            state_q <= state_d;
            hold_q  <= (state_d == HOLD);
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_evt),
        .clr   (1'b0),
        .q     (cnt_stall)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt_flush (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush),
        .clr   (1'b0),
        .q     (cnt_flush)
    );

    assign id_pc    = slot_q.pc;
    assign id_inst  = slot_q.inst;
    assign id_valid = slot_q.valid;
    assign hold_o   = hold_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed bench for the IF/ID pipeline register: a 16-bit-counter instance
// and a 4-bit-counter instance share the same stimulus.
module tb_if_id_reg;
    import core_pkg::*;

    logic                   clk;
    logic                   rst_n;
    logic [STALL_WIDTH-1:0] stall;
    logic                   flush;
    logic [31:0]            if_pc;
    logic [31:0]            if_inst;

    logic [31:0] id_pc,    s_id_pc;
    logic [31:0] id_inst,  s_id_inst;
    logic        id_valid, s_id_valid;
    logic        hold_o,   s_hold_o;
    logic [15:0] cnt_stall, cnt_flush;
    logic [3:0]  s_cnt_stall, s_cnt_flush;

    int checks;
    int errors;

    if_id_reg #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .id_pc     (id_pc),
        .id_inst   (id_inst),
        .id_valid  (id_valid),
        .hold_o    (hold_o),
        .cnt_stall (cnt_stall),
        .cnt_flush (cnt_flush)
    );

    if_id_reg #(.CNT_W(4)) dut_s (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .flush     (flush),
        .if_pc     (if_pc),
        .if_inst   (if_inst),
        .id_pc     (s_id_pc),
        .id_inst   (s_id_inst),
        .id_valid  (s_id_valid),
        .hold_o    (s_hold_o),
        .cnt_stall (s_cnt_stall),
        .cnt_flush (s_cnt_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [STALL_WIDTH-1:0] st, input logic fl,
                         input logic [31:0] pc, input logic [31:0] inst);
        stall   = st;
        flush   = fl;
        if_pc   = pc;
        if_inst = inst;
    endtask

    task automatic check_slot(input string tag, input logic [31:0] pc,
                              input logic [31:0] inst, input logic vld, input logic hold);
        check({tag, ".pc"},    id_pc,    pc);
        check({tag, ".inst"},  id_inst,  inst);
        check({tag, ".valid"}, {31'd0, id_valid}, {31'd0, vld});
        check({tag, ".hold"},  {31'd0, hold_o},   {31'd0, hold});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(STALL_NONE, 1'b0, 32'h0, 32'h0);

        // Reset state
        step();
        step();
        check_slot("rst", 32'h0, 32'h0000_0013, 1'b0, 1'b0);
        check("rst.cnt_stall", {16'd0, cnt_stall}, 32'd0);
        check("rst.cnt_flush", {16'd0, cnt_flush}, 32'd0);

        // Capture on first edge after deassert
        rst_n = 1'b1;
        drive(STALL_NONE, 1'b0, 32'h100, 32'h0050_0093);
        step();
        check_slot("cap", 32'h100, 32'h0050_0093, 1'b1, 1'b0);

        // Three load stalls while IF keeps changing
        for (int i = 0; i < 3; i++) begin
            drive(STALL_LOAD, 1'b0, 32'h104 + 32'(4 * i), 32'hDEAD_0000 + 32'(i));
            step();
            check_slot("stall", 32'h100, 32'h0050_0093, 1'b1, 1'b1);
            check("stall.cnt", {16'd0, cnt_stall}, 32'(i + 1));
        end

        // Release
        drive(STALL_NONE, 1'b0, 32'h10C, 32'h0060_0113);
        step();
        check_slot("rel", 32'h10C, 32'h0060_0113, 1'b1, 1'b0);
        check("rel.cnt_stall", {16'd0, cnt_stall}, 32'd3);

        // Flush
        drive(STALL_NONE, 1'b1, 32'h110, 32'h00A0_0113);
        step();
        check_slot("flush", 32'h110, 32'h0000_0013, 1'b0, 1'b0);
        check("flush.cnt", {16'd0, cnt_flush}, 32'd1);

        drive(STALL_NONE, 1'b0, 32'h114, 32'h0070_0193);
        step();
        check_slot("postflush", 32'h114, 32'h0070_0193, 1'b1, 1'b0);

        // Enter HOLD, then flush and stall together
        drive(STALL_LOAD, 1'b0, 32'h118, 32'h0000_1111);
        step();
        check_slot("hold", 32'h114, 32'h0070_0193, 1'b1, 1'b1);
        check("hold.cnt", {16'd0, cnt_stall}, 32'd4);
        drive(STALL_LOAD, 1'b1, 32'h11C, 32'h0000_2222);
        step();
        check_slot("simul", 32'h11C, 32'h0000_0013, 1'b0, 1'b0);
        check("simul.cnt_stall", {16'd0, cnt_stall}, 32'd4);
        check("simul.cnt_flush", {16'd0, cnt_flush}, 32'd2);

        // Held bubble stays a bubble
        drive(STALL_LOAD, 1'b0, 32'h120, 32'h0000_3333);
        step();
        check_slot("hbub", 32'h11C, 32'h0000_0013, 1'b0, 1'b1);
        check("hbub.cnt", {16'd0, cnt_stall}, 32'd5);

        // Non-load stall code is a plain capture
        drive(STALL_MEM, 1'b0, 32'h124, 32'h0080_0213);
        step();
        check_slot("othstall", 32'h124, 32'h0080_0213, 1'b1, 1'b0);
        check("othstall.cnt", {16'd0, cnt_stall}, 32'd5);

        // Saturation: 4-bit counter goes 5 -> 14 -> sticks at 15, 16-bit reaches 25
        drive(STALL_LOAD, 1'b0, 32'h128, 32'h0000_4444);
        for (int i = 0; i < 9; i++) step();
        check("sat.pre", {28'd0, s_cnt_stall}, 32'd14);
        for (int i = 0; i < 11; i++) step();
        check("sat.stick", {28'd0, s_cnt_stall}, 32'd15);
        check("sat.wide", {16'd0, cnt_stall}, 32'd25);
        check("sat.flush4", {28'd0, s_cnt_flush}, 32'd2);

        // Mid-stream asynchronous reset
        drive(STALL_NONE, 1'b0, 32'h200, 32'h0090_0293);
        step();
        check("mid.valid_before", {31'd0, id_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_slot("arst", 32'h0, 32'h0000_0013, 1'b0, 1'b0);
        check("arst.cnt_stall", {16'd0, cnt_stall}, 32'd0);
        check("arst.cnt_flush", {16'd0, cnt_flush}, 32'd0);
        check("arst.s_cnt", {28'd0, s_cnt_stall}, 32'd0);
        step();
        rst_n = 1'b1;
        drive(STALL_NONE, 1'b0, 32'h204, 32'h00A0_0313);
        step();
        check_slot("rerun", 32'h204, 32'h00A0_0313, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
